// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared bundle widths and control-field offsets for pipeline stage registers
package pipe_pkg;

    // EX/MEM boundary bundle widths
    localparam int EXMEM_CTRL_W = 15;
    localparam int EXMEM_DATA_W = 96;

    // EX/MEM control field offsets, MSB first: WriteAddress, Jtype, RegWrite,
    // MemRead, MemWrite, Branch, ALUSelect (ALUSelect occupies the low bits)
    localparam int ALUSEL_LSB = 0;
    localparam int ALUSEL_W   = 5;
    localparam int BRANCH     = 5;
    localparam int MEMWRITE   = 6;
    localparam int MEMREAD    = 7;
    localparam int REGWRITE   = 8;
    localparam int JTYPE      = 9;
    localparam int WADDR_LSB  = 10;
    localparam int WADDR_W    = 5;

    // Field view of the EX/MEM control bundle, bit-compatible with the offsets above
    typedef struct packed {
        logic [WADDR_W-1:0]  writeAddress;
        logic                jtype;
        logic                regWrite;
        logic                memRead;
        logic                memWrite;
        logic                branch;
        logic [ALUSEL_W-1:0] aluSelect;
    } exMemCtrl_t;

    // True when the control bundle would cause an architectural side effect
    function automatic logic hasSideEffect(input logic [EXMEM_CTRL_W-1:0] ctrl);
        return ctrl[REGWRITE] | ctrl[MEMWRITE] | ctrl[MEMREAD] | ctrl[BRANCH];
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one {valid,ctrl,data} holding register with load and clear
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] loadCtrl,
    input  logic [DATA_W-1:0] loadData,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Clear wins over load; clearing zeroes ctrl so a bubble never carries side effects, data is kept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= loadCtrl;
            data  <= loadData;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline stage register with bubble masking, flush and optional skid entry
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int SKID   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              inFire;
    logic              outFire;
    logic              mainValid;
    logic              mainLoad;
    logic              mainClear;
    logic [CTRL_W-1:0] mainCtrlIn;
    logic [DATA_W-1:0] mainDataIn;
    logic              skidValid;

    assign inFire  = in_valid & in_ready;
    assign outFire = mainValid & out_ready;

    // The main entry drives the outputs directly, so out_ctrl is a zeroed register, never a gated one
    pipe_skid_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) mainEntry (
        .clk      (clk),
        .reset    (reset),
        .load     (mainLoad),
        .clear    (mainClear),
        .loadCtrl (mainCtrlIn),
        .loadData (mainDataIn),
        .valid    (mainValid),
        .ctrl     (out_ctrl),
        .data     (out_data)
    );

    assign out_valid = mainValid;

    generate
        if (SKID == 0) begin : genSingle
            // Single entry: can accept whenever the held entry leaves this cycle
            assign in_ready   = !mainValid | out_ready;
            assign mainLoad   = inFire;
            assign mainClear  = flush | (outFire & !inFire);
            assign mainCtrlIn = in_ctrl;
            assign mainDataIn = in_data;
            assign skidValid  = 1'b0;
        end else begin : genSkid
            logic              skidLoad;
            logic              skidClear;
            logic [CTRL_W-1:0] skidCtrl;
            logic [DATA_W-1:0] skidData;

            // in_ready comes straight from the skid register, cutting the out_ready to in_ready path
            assign in_ready = !skidValid;

            // Two-entry FIFO steering: the skid entry always drains into main before new input does
            always_comb begin
                mainLoad   = 1'b0;
                mainClear  = 1'b0;
                skidLoad   = 1'b0;
                skidClear  = 1'b0;
                mainCtrlIn = in_ctrl;
                mainDataIn = in_data;
                if (flush) begin
                    mainClear = 1'b1;
                    skidClear = 1'b1;
                end else if (skidValid) begin
                    if (outFire) begin
                        mainLoad   = 1'b1;
                        mainCtrlIn = skidCtrl;
                        mainDataIn = skidData;
                        skidClear  = 1'b1;
                    end
                end else if (inFire && (!mainValid || outFire)) begin
                    mainLoad = 1'b1;
                end else if (inFire) begin
                    skidLoad = 1'b1;
                end else if (outFire) begin
                    mainClear = 1'b1;
                end
            end

            pipe_skid_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) skidEntry (
                .clk      (clk),
                .reset    (reset),
                .load     (skidLoad),
                .clear    (skidClear),
                .loadCtrl (in_ctrl),
                .loadData (in_data),
                .valid    (skidValid),
                .ctrl     (skidCtrl),
                .data     (skidData)
            );
        end
    endgenerate

    assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

    // Saturating count of cycles the downstream stalled a valid output; flush leaves it alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (mainValid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
